// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands
  typedef logic [1:0] dig_idx_t;

  // Four BCD digits; element 0 is the ones digit.
  typedef logic [3:0][3:0] bcd4_t;

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Combinational BCD to active-low seven-segment pattern.
// Codes 10..15 render as a dash (segment g only).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup; any non-BCD code becomes a dash
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-anode display driver with double buffering.
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       upd,
  output logic       pending,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_V = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  dig_idx_t      idx_q, idx_d;
  bcd4_t         stg_q, stg_d;
  bcd4_t         disp_q, disp_d;
  logic          pend_q, pend_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  bcd4_t      din;
  logic       slot_end;
  logic       xfer;
  logic [3:0] cur;
  logic [6:0] dec_seg;
  logic       blank;

  assign din      = {thousands, hundreds, tens, ones};
  assign slot_end = (cnt_q == CNT_MAX);
  assign xfer     = slot_end && (idx_q == 2'd3);
  assign cur      = disp_q[idx_q];

  seg7_decode u_dec (
    .bcd (cur),
    .seg (dec_seg)
  );

  // Prescaler and digit index advance
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Staging buffer and frame transfer at the end of the thousands slot
  always_comb begin
    stg_d  = stg_q;
    disp_d = disp_q;
    pend_d = pend_q;
    if (upd) begin
      stg_d = din;
    end
    if (xfer) begin
      pend_d = 1'b0;
      if (upd) begin
        disp_d = din;
      end else if (pend_q) begin
        disp_d = stg_q;
      end
    end else if (upd) begin
      pend_d = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] lz;

  // A digit is blank when it and every digit to its left are zero
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (disp_q[3] == 4'd0);
    lz[2] = lz[3] && (disp_q[2] == 4'd0);
    lz[1] = lz[2] && (disp_q[1] == 4'd0);
    lz[0] = 1'b0;
    blank = lz[idx_q];
  end
`else
  assign blank = 1'b0;
`endif

  // Next anode/cathode pattern; guard interval keeps all anodes off
  always_comb begin
    seg_d = blank ? SEG_OFF : dec_seg;
    an_d  = AN_OFF;
    if (cnt_q >= BLANK_V) begin
      unique case (idx_q)
        2'd0: an_d = 4'b1110;
        2'd1: an_d = 4'b1101;
        2'd2: an_d = 4'b1011;
        2'd3: an_d = 4'b0111;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      stg_q  <= '0;
      disp_q <= '0;
      pend_q <= 1'b0;
      an_q   <= AN_OFF;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      stg_q  <= stg_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign pending = pend_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYC=1).
// Expected slots are queued by stimulus and popped when a digit lights.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] thousands, hundreds, tens, ones;
  logic       upd;
  logic       pending;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_driver #(
    .SCAN_DIV  (8),
    .BLANK_CYC (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .upd       (upd),
    .pending   (pending),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   e = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic [3:0] pmask, input int nslots);
    logic [3:0] dg[4];
    logic [3:0] bl;
    exp_t       x;
    dg[0] = d0; dg[1] = d1; dg[2] = d2; dg[3] = d3;
    bl = 4'b0000;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    bl[3] = (d3 == 4'd0);
    bl[2] = bl[3] && (d2 == 4'd0);
    bl[1] = bl[2] && (d1 == 4'd0);
`endif
    for (int i = 0; i < nslots; i++) begin
      x.an   = ~(4'b0001 << i);
      x.seg  = bl[i] ? 7'b1111111 : seg_of(dg[i]);
      x.pend = pmask[i];
      q.push_back(x);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic goto(input int k);
    while (e < k) step();
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    thousands = a; hundreds = b; tens = c; ones = d;
  endtask

  // Monitor: pops an expected slot each time a digit lights up
  logic [3:0] prev_an = 4'hF;
  int  lit_run = 0;
  int  blank_run = 0;
  bit  have_prev = 0;
  bit  rst_seen = 0;

  always @(negedge clk) begin
    exp_t x;
    if (rst_n !== 1'b1) begin
      rst_seen = 1;
      have_prev = 0;
    end
    chk("dp_off", {31'd0, dp}, 32'd1);
    if (an !== 4'hF)
      chk("one_anode", $countones(~an), 32'd1);
    if (an !== 4'hF && prev_an === 4'hF) begin
      if (have_prev && !rst_seen) begin
        chk("lit_len", lit_run, 32'd7);
        chk("guard_len", blank_run, 32'd1);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot: got an=%b seg=%b expected none",
                 an, seg);
      end else begin
        x = q.pop_front();
        chk("slot_an", {28'd0, an}, {28'd0, x.an});
        chk("slot_seg", {25'd0, seg}, {25'd0, x.seg});
        chk("slot_pend", {31'd0, pending}, {31'd0, x.pend});
      end
      have_prev = 1;
      rst_seen = 0;
      lit_run = 1;
      blank_run = 0;
    end else if (an !== 4'hF) begin
      lit_run++;
    end else begin
      blank_run++;
    end
    prev_an = an;
  end

  initial begin
    rst_n = 1'b0;
    upd   = 1'b0;
    set_in(0, 0, 0, 0);

    push_frame(0, 0, 0, 0, 4'b1100, 4);
    repeat (3) begin
      step();
      chk("rst_an", {28'd0, an}, 32'hF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_pend", {31'd0, pending}, 32'd0);
    end
    rst_n = 1'b1;
    e = 0;

    goto(10);
    set_in(1, 2, 3, 4);
    upd = 1'b1;
    push_frame(1, 2, 3, 4, 4'b0000, 4);
    step();
    upd = 1'b0;
    chk("pend_set", {31'd0, pending}, 32'd1);

    goto(31);
    chk("pend_before_xfer", {31'd0, pending}, 32'd1);
    step();
    chk("pend_after_xfer", {31'd0, pending}, 32'd0);

    goto(63);
    set_in(9, 9, 9, 9);
    upd = 1'b1;
    push_frame(9, 9, 9, 9, 4'b1110, 4);
    step();
    upd = 1'b0;
    chk("pend_coincident", {31'd0, pending}, 32'd0);

    goto(69);
    set_in(5, 5, 5, 5);
    upd = 1'b1;
    push_frame(15, 0, 0, 0, 4'b0000, 4);
    step();
    upd = 1'b0;

    goto(79);
    set_in(15, 0, 0, 0);
    upd = 1'b1;
    step();
    upd = 1'b0;

    goto(95);
    chk("pend_overwrite", {31'd0, pending}, 32'd1);
    step();
    chk("pend_ow_clear", {31'd0, pending}, 32'd0);

    goto(130);
    set_in(1, 2, 3, 4);
    upd = 1'b1;
    push_frame(15, 0, 0, 0, 4'b0110, 3);
    step();
    upd = 1'b0;

    goto(147);
    chk("pend_pre_rst", {31'd0, pending}, 32'd1);
    rst_n = 1'b0;
    push_frame(0, 0, 0, 0, 4'b1110, 4);
    step();
    chk("midrst_an", {28'd0, an}, 32'hF);
    chk("midrst_seg", {25'd0, seg}, 32'h7F);
    chk("midrst_pend", {31'd0, pending}, 32'd0);
    rst_n = 1'b1;
    e = 0;

    goto(6);
    set_in(0, 0, 4, 2);
    upd = 1'b1;
    push_frame(0, 0, 4, 2, 4'b0000, 4);
    step();
    upd = 1'b0;

    goto(64);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes four BCD digits (thousands/hundreds/tens/ones) from the binary-to-BCD converter and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Time-multiplexes one digit at a time at a programmable scan rate.
- Double-buffers incoming digits so a display frame never mixes old and new values.
- Inserts an all-off guard interval at each digit switch to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYC, 2, cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- thousands  in  4  BCD digit 3 (leftmost).
- hundreds  in  4  BCD digit 2.
- tens  in  4  BCD digit 1.
- ones  in  4  BCD digit 0 (rightmost).
- upd  in  1  one-cycle strobe: capture the four digit inputs into the staging buffer.
- pending  out  1  high while the staging buffer holds data not yet shown.
- an  out  4  anode enables, active-low; an[0] = ones.
- seg  out  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low; always 1 (off).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - an=4'b1111, seg=7'b1111111, dp=1, pending=0.
  - Prescaler=0, digit index=0; staging and display buffers all 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - slot_end asserts when the count equals SCAN_DIV-1.
  - At slot_end the digit index increments mod 4 (0 = ones, 1 = tens, 2 = hundreds, 3 = thousands, then back to 0).
- Staging:
  - upd=1 loads the staging buffer from the inputs and sets pending=1.
  - A later upd before transfer overwrites the buffer (last value wins; no loss flag).
- Frame transfer:
  - Occurs when slot_end=1 and index=3: the display buffer loads from staging, and pending clears.
  - If upd coincides with the transfer cycle, the digits presented in that same cycle are transferred and pending stays 0.
  - With no pending data, the display buffer holds.
- Output timing (registered; one cycle after the prescaler/index state):
  - While prescaler < BLANK_CYC: an=4'b1111 and seg holds the new digit's pattern.
  - Otherwise an drives a single 0 at bit [index].
- seg encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Non-BCD 10..15 = 0111111 (dash, segment g only).
- Reset mid-scan returns everything to the reset state on the next edge; any pending staging data is discarded.
- Exactly one anode is ever low; never two.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined:
  - A display digit is blanked (seg=1111111, anode still scanned) when it is 0 and every digit to its left is also 0.
  - The ones digit is never blanked, so value 0 shows a single "0".
  - Example: 0,0,4,2 shows "  42"; 1,0,0,5 shows "1005".
- Not defined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg:
  - Constants for the 7-bit active-low patterns (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
  - Constant AN_OFF = 4'b1111.
  - A digit-index typedef (2 bits).
- Sub-module seg7_decode: purely combinational, 4-bit BCD to 7-bit active-low pattern.
- seg7_scan_driver: owns the prescaler, index, staging/display buffers, blanking logic and output registers.

Test Plan:
- Reset/idle: SCAN_DIV=8, BLANK_CYC=1, hold rst_n=0 for 3 cycles, then release.
  - During reset: an=1111, seg=1111111, dp=1, pending=0.
  - After release: an sequence 1110,1101,1011,0111 repeating; each slot lasts 8 cycles, with the first cycle of each slot 1111.
- Update/transfer: SCAN_DIV=8, BLANK_CYC=1, upd with 1,2,3,4 mid-slot at index 1.
  - pending=1 until the end of the index-3 slot, then clears.
  - Next frame shows seg 1111001 on an=0111 and 0011001 on an=1110.
  - No digit of 1,2,3,4 appears in the partial frame before transfer.
- Coincident upd: SCAN_DIV=8, BLANK_CYC=1, upd with 9,9,9,9 exactly on the index-3 slot_end cycle.
  - The next frame shows 0010000 on all digits; pending never rises.
- Overwrite and invalid: SCAN_DIV=8, BLANK_CYC=1.
  - upd 5,5,5,5 then upd 15,0,0,0 before transfer.
  - Frame shows dash 0111111 on the thousands digit and 1000000 on the others.
- Reset mid-scan: SCAN_DIV=8, BLANK_CYC=1, assert rst_n=0 for one cycle at index 2 with pending=1.
  - Next cycle: an=1111, pending=0; the scan restarts at index 0 showing 1000000.
- Leading-zero (macro defined): SCAN_DIV=8, BLANK_CYC=1.
  - Inputs 0,0,4,2 give thousands/hundreds seg 1111111 and tens/ones 0011001/0100100.
  - Inputs 0,0,0,0 show only ones 1000000.
